// File: rtl/adder_pkg.sv
// Shared defaults and the elaboration-time legality rule for the pipelined adder.
package adder_pkg;

    localparam int DEFAULT_N      = 32;
    localparam int DEFAULT_STAGES = 4;

    // True when `stages` splits `n` into equal, non-empty chunks.
    function automatic bit split_ok(input int n, input int stages);
        return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple adder slice; one instance per pipeline stage.
module adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_pipelined.sv
// Pipelined N-bit add/subtract: STAGES ripple chunks, one per stage, valid/ready on both ends.
// Define ADDER_PIPELINED_OVERFLOW_EN to add the registered signed-overflow output ovf.
module adder_pipelined
    import adder_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout
`ifdef ADDER_PIPELINED_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);

    localparam int W = N / STAGES;

    if (!split_ok(N, STAGES)) begin : g_bad_split
        $error("adder_pipelined: N=%0d is not a positive multiple of STAGES=%0d", N, STAGES);
    end

    logic [STAGES-1:0] v;
    logic [STAGES:0]   adv;

    // A stage advances if it is empty or its successor advances; the chain starts at out_ready.
    // NOTE: every bit of adv is assigned on every evaluation, so no latch is inferred.
    always_comb begin
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = ~v[k] | adv[k+1];
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = N - k * W;  // operand bits not yet consumed when entering stage k

        logic [IW-1:0]        op_a;
        logic [IW-1:0]        op_b;
        logic                 up_valid;
        logic                 up_carry;
        logic [W-1:0]         chunk_s;
        logic                 chunk_co;
        logic [(k+1)*W-1:0]   sum_acc;

        if (k == 0) begin : g_src
            assign op_a     = a;
            assign op_b     = sub ? ~b : b;
            assign up_carry = sub | cin;
            assign up_valid = in_valid;
            assign sum_acc  = chunk_s;
        end else begin : g_src
            assign op_a     = g_stage[k-1].g_reg.q.a_hi;
            assign op_b     = g_stage[k-1].g_reg.q.b_hi;
            assign up_carry = g_stage[k-1].g_reg.q.carry;
            assign up_valid = g_stage[k-1].g_reg.q.valid;
            assign sum_acc  = {chunk_s, g_stage[k-1].g_reg.q.sum_lo};
        end

        adder_chunk #(.W(W)) u_chunk (
            .a    (op_a[W-1:0]),
            .b    (op_b[W-1:0]),
            .cin  (up_carry),
            .s    (chunk_s),
            .cout (chunk_co)
        );

        if (k < STAGES - 1) begin : g_reg
            typedef struct packed {
                logic                 valid;
                logic                 carry;
                logic [(k+1)*W-1:0]   sum_lo;
                logic [IW-W-1:0]      a_hi;
                logic [IW-W-1:0]      b_hi;
            } stage_t;

            stage_t q;

            // NOTE: state registers use non-blocking assignments so each stage samples pre-edge values.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (adv[k]) begin
                    q <= '{valid:  up_valid,
                           carry:  chunk_co,
                           sum_lo: sum_acc,
                           a_hi:   op_a[IW-1:W],
                           b_hi:   op_b[IW-1:W]};
                end
            end
        end else begin : g_reg
            typedef struct packed {
                logic                 valid;
                logic                 carry;
                logic [N-1:0]         sum_lo;
`ifdef ADDER_PIPELINED_OVERFLOW_EN
                logic                 ovf;
`endif
            } stage_t;

            stage_t q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (adv[k]) begin
                    q.valid  <= up_valid;
                    q.carry  <= chunk_co;
                    q.sum_lo <= sum_acc;
`ifdef ADDER_PIPELINED_OVERFLOW_EN
                    // a^b^s at the MSB recovers the carry into it; xor with carry out gives overflow.
                    q.ovf    <= op_a[W-1] ^ op_b[W-1] ^ chunk_s[W-1] ^ chunk_co;
`endif
                end
            end
        end

        assign v[k] = g_reg.q.valid;
    end

    assign out_valid = g_stage[STAGES-1].g_reg.q.valid;
    assign s         = g_stage[STAGES-1].g_reg.q.sum_lo;
    assign cout      = g_stage[STAGES-1].g_reg.q.carry;
`ifdef ADDER_PIPELINED_OVERFLOW_EN
    assign ovf       = g_stage[STAGES-1].g_reg.q.ovf;
`endif

endmodule
